// File: rtl/uart_axi_tx.sv
// -----------------------------------------------------------------------------
// uart_axi_tx
//   AXI4-Lite slave that feeds an 8N1 UART transmitter through a small FIFO.
//
//   Register map (only addr[11:0] is decoded, prot inputs are ignored):
//     0x018 DIV    rw  bits[15:0] clk cycles per bit (bit time is max(div,4))
//     0x02C STATUS ro  bit3 fifo empty, bit4 fifo full, bit5 busy,
//                      bit8 sticky overflow (cleared by reading STATUS)
//     0x030 TXDATA wo  bits[7:0] byte pushed into the TX FIFO
//
//   Ports:
//     clk, reset              rising-edge clock, synchronous active-high reset
//     mem_axi_aw*/w*/b*       AXI4-Lite write address / data / response
//     mem_axi_ar*/r*          AXI4-Lite read address / data
//     uart_tx                 serial output, idle high
// -----------------------------------------------------------------------------
module uart_axi_tx #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned DEFAULT_DIV = 868
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        mem_axi_awvalid,
    output logic        mem_axi_awready,
    input  logic [31:0] mem_axi_awaddr,
    input  logic [2:0]  mem_axi_awprot,

    input  logic        mem_axi_wvalid,
    output logic        mem_axi_wready,
    input  logic [31:0] mem_axi_wdata,
    input  logic [3:0]  mem_axi_wstrb,

    output logic        mem_axi_bvalid,
    input  logic        mem_axi_bready,

    input  logic        mem_axi_arvalid,
    output logic        mem_axi_arready,
    input  logic [31:0] mem_axi_araddr,
    input  logic [2:0]  mem_axi_arprot,

    output logic        mem_axi_rvalid,
    input  logic        mem_axi_rready,
    output logic [31:0] mem_axi_rdata,

    output logic        uart_tx
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]      DIV_RESET = 16'(DEFAULT_DIV);
    localparam logic [15:0]      MIN_BIT   = 16'd4;

    localparam logic [11:0] ADDR_DIV    = 12'h018;
    localparam logic [11:0] ADDR_STATUS = 12'h02C;
    localparam logic [11:0] ADDR_TXDATA = 12'h030;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              awready_q,  awready_d;
    logic              bvalid_q,   bvalid_d;
    logic              arready_q,  arready_d;
    logic              rvalid_q,   rvalid_d;
    logic [31:0]       rdata_q,    rdata_d;
    logic [15:0]       div_q,      div_d;
    logic              overflow_q, overflow_d;

    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic [7:0]        fifo_mem [FIFO_DEPTH];

    tx_state_e         state_q,    state_d;
    logic [7:0]        shreg_q,    shreg_d;
    logic [15:0]       bit_len_q,  bit_len_d;
    logic [15:0]       cyc_cnt_q,  cyc_cnt_d;
    logic [2:0]        bit_idx_q,  bit_idx_d;
    logic              tx_q,       tx_d;

    // ------------------------------------------------------------------
    // Handshake and decode terms
    // ------------------------------------------------------------------
    logic        wr_hs;
    logic        rd_hs;
    logic [11:0] wr_addr;
    logic [11:0] rd_addr;
    logic        txdata_wr;
    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic        ovf_set;
    logic        status_rd;
    logic        bit_end;
    logic [31:0] rd_value;

    assign wr_addr    = mem_axi_awaddr[11:0];
    assign rd_addr    = mem_axi_araddr[11:0];
    assign wr_hs      = awready_q && mem_axi_awvalid && mem_axi_wvalid;
    assign rd_hs      = arready_q && mem_axi_arvalid;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);

    // A byte lane 0 write to TXDATA either lands in the FIFO or is dropped
    // and recorded as an overflow; the bus transaction completes either way.
    assign txdata_wr  = wr_hs && (wr_addr == ADDR_TXDATA) && mem_axi_wstrb[0];
    assign push       = txdata_wr && !fifo_full;
    assign ovf_set    = txdata_wr && fifo_full;
    assign pop        = (state_q == IDLE) && !fifo_empty;
    assign status_rd  = rd_hs && (rd_addr == ADDR_STATUS);

    assign bit_end    = (cyc_cnt_q == bit_len_q - 16'd1);

    // Address/prot bits outside the decoded window and unused byte lanes.
    logic unused_inputs;
    assign unused_inputs = ^{mem_axi_awaddr[31:12], mem_axi_araddr[31:12],
                             mem_axi_awprot, mem_axi_arprot,
                             mem_axi_wdata[31:16], mem_axi_wstrb[3:2]};

    // ------------------------------------------------------------------
    // Write channel and DIV register
    // ------------------------------------------------------------------
    // NOTE: every signal driven in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        // Ready is a registered one-cycle pulse: it cannot re-arm while the
        // response is pending or in the cycle right after it fired.
        awready_d = mem_axi_awvalid && mem_axi_wvalid && !bvalid_q && !awready_q;
        bvalid_d  = wr_hs || (bvalid_q && !mem_axi_bready);
        div_d     = div_q;
        if (wr_hs && (wr_addr == ADDR_DIV)) begin
            if (mem_axi_wstrb[0]) div_d[7:0]  = mem_axi_wdata[7:0];
            if (mem_axi_wstrb[1]) div_d[15:8] = mem_axi_wdata[15:8];
        end
    end

    // ------------------------------------------------------------------
    // Read channel, STATUS and overflow
    // ------------------------------------------------------------------
    always_comb begin
        rd_value = '0;
        case (rd_addr)
            ADDR_DIV: rd_value = {16'h0, div_q};
            ADDR_STATUS: begin
                rd_value[3] = fifo_empty;
                rd_value[4] = fifo_full;
                rd_value[5] = (state_q != IDLE);
                rd_value[8] = overflow_q;
            end
            default: rd_value = '0;
        endcase
    end

    always_comb begin
        arready_d  = mem_axi_arvalid && !rvalid_q && !arready_q;
        rvalid_d   = rd_hs || (rvalid_q && !mem_axi_rready);
        rdata_d    = rd_hs ? rd_value : rdata_q;
        overflow_d = overflow_q;
        if (status_rd) overflow_d = 1'b0;
        // Ordered after the clear: an overflow in the read cycle itself must
        // survive, because the value just returned did not report it.
        if (ovf_set)   overflow_d = 1'b1;
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // NOTE: FIFO storage has no reset; the pointers and count are reset, so
    // a stale entry can never be popped and the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= mem_axi_wdata[7:0];
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_len_d = bit_len_q;
        cyc_cnt_d = cyc_cnt_q;
        bit_idx_d = bit_idx_q;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    // Divisor is captured here so DIV writes mid-frame only
                    // affect the next frame.
                    state_d   = START;
                    shreg_d   = fifo_mem[rd_ptr_q];
                    bit_len_d = (div_q < MIN_BIT) ? MIN_BIT : div_q;
                    cyc_cnt_d = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    cyc_cnt_d = '0;
                    bit_idx_d = '0;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cyc_cnt_d = '0;
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d   = IDLE;
                    cyc_cnt_d = '0;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The line level is derived from the next state so the output flop
        // changes in the same cycle as the state register.
        tx_d = 1'b1;
        if (state_d == START)     tx_d = 1'b0;
        else if (state_d == DATA) tx_d = shreg_d[0];
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated only with non-blocking assignments,
    // so every flop samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            div_q      <= DIV_RESET;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_len_q  <= MIN_BIT;
            cyc_cnt_q  <= '0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
        end else begin
            awready_q  <= awready_d;
            bvalid_q   <= bvalid_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            div_q      <= div_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_len_q  <= bit_len_d;
            cyc_cnt_q  <= cyc_cnt_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
        end
    end

    // AW and W share one ready flop so they can never be accepted apart.
    assign mem_axi_awready = awready_q;
    assign mem_axi_wready  = awready_q;
    assign mem_axi_bvalid  = bvalid_q;
    assign mem_axi_arready = arready_q;
    assign mem_axi_rvalid  = rvalid_q;
    assign mem_axi_rdata   = rdata_q;
    assign uart_tx         = tx_q;

endmodule

// File: tb/tb_uart_axi_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_axi_tx
//   Directed bench for uart_axi_tx with default parameters (FIFO_DEPTH=16,
//   DEFAULT_DIV=868). Inputs change and outputs are sampled on the falling
//   clock edge; the DUT registers everything on the rising edge.
// -----------------------------------------------------------------------------
module tb_uart_axi_tx;

    localparam logic [31:0] A_DIV    = 32'h0000_0018;
    localparam logic [31:0] A_STATUS = 32'h0000_002C;
    localparam logic [31:0] A_TXDATA = 32'h0000_0030;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        awvalid = 1'b0, awready;
    logic [31:0] awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        wvalid = 1'b0, wready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        bvalid, bready = 1'b0;
    logic        arvalid = 1'b0, arready;
    logic [31:0] araddr = '0;
    logic [2:0]  arprot = '0;
    logic        rvalid, rready = 1'b0;
    logic [31:0] rdata;
    logic        uart_tx;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_axi_tx dut (
        .clk             (clk),
        .reset           (reset),
        .mem_axi_awvalid (awvalid),
        .mem_axi_awready (awready),
        .mem_axi_awaddr  (awaddr),
        .mem_axi_awprot  (awprot),
        .mem_axi_wvalid  (wvalid),
        .mem_axi_wready  (wready),
        .mem_axi_wdata   (wdata),
        .mem_axi_wstrb   (wstrb),
        .mem_axi_bvalid  (bvalid),
        .mem_axi_bready  (bready),
        .mem_axi_arvalid (arvalid),
        .mem_axi_arready (arready),
        .mem_axi_araddr  (araddr),
        .mem_axi_arprot  (arprot),
        .mem_axi_rvalid  (rvalid),
        .mem_axi_rready  (rready),
        .mem_axi_rdata   (rdata),
        .uart_tx         (uart_tx)
    );

    // ------------------------------------------------------------------
    // Bus tasks: start and end on a falling edge
    // ------------------------------------------------------------------
    task automatic do_reset();
        reset = 1'b1; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arvalid = 1'b0; rready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int hold);
        int n = 0;
        awaddr = addr; awprot = 3'b010; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        while (awready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (awready !== 1'b1 || wready !== 1'b1) begin
            failures++;
            $display("FAIL wr_ready addr=%h: awready=%b wready=%b after %0d cycles, need 1/1", addr, awready, wready, n);
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        @(negedge clk);
        checks++;
        if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
            failures++;
            $display("FAIL wr_resp addr=%h: bvalid=%b awready=%b wready=%b, need 1/0/0", addr, bvalid, awready, wready);
        end
        // Valids stay high during the hold to prove no second acceptance.
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
                failures++;
                $display("FAIL wr_hold cycle %0d: bvalid=%b awready=%b wready=%b, need 1/0/0", i, bvalid, awready, wready);
            end
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0) begin
            failures++;
            $display("FAIL wr_bclear addr=%h: bvalid=%b, need 0", addr, bvalid);
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, input int hold);
        int n = 0;
        data = '0;
        araddr = addr; arprot = 3'b001; arvalid = 1'b1;
        while (arready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (arready !== 1'b1) begin
            failures++;
            $display("FAIL rd_ready addr=%h: arready=%b after %0d cycles, need 1", addr, arready, n);
            arvalid = 1'b0;
            return;
        end
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b1 || arready !== 1'b0) begin
            failures++;
            $display("FAIL rd_valid addr=%h: rvalid=%b arready=%b, need 1/0", addr, rvalid, arready);
        end
        data = rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (rvalid !== 1'b1 || arready !== 1'b0 || rdata !== data) begin
                failures++;
                $display("FAIL rd_hold cycle %0d: rvalid=%b arready=%b rdata=%h, need 1/0/%h", i, rvalid, arready, rdata, data);
            end
        end
        arvalid = 1'b0; rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rd_rclear addr=%h: rvalid=%b, need 0", addr, rvalid);
        end
    endtask

    // Compares one 8N1 frame cycle by cycle; with search=0 the start bit must
    // already be on the line at the current sample.
    task automatic check_frame(input logic [7:0] b, input int bit_len, input bit search, input string name);
        logic [9:0] frame;
        logic       got;
        int         n = 0;
        int         bad_c;
        frame = {1'b1, b, 1'b0};
        if (search) begin
            while (uart_tx !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
            checks++;
            if (uart_tx !== 1'b0) begin
                failures++;
                $display("FAIL %s start: uart_tx=%b after %0d cycles, need 0", name, uart_tx, n);
                return;
            end
        end
        for (int i = 0; i < 10; i++) begin
            bad_c = -1; got = 1'b0;
            for (int c = 0; c < bit_len; c++) begin
                if (uart_tx !== frame[i] && bad_c < 0) begin bad_c = c; got = uart_tx; end
                @(negedge clk);
            end
            checks++;
            if (bad_c >= 0) begin
                failures++;
                $display("FAIL %s bit%0d: uart_tx=%b at cycle %0d of bit, need %b", name, i, got, bad_c, frame[i]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, uart_tx} !== 6'b000001 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: aw/w/b/ar/r/tx=%b%b%b%b%b%b rdata=%h, need 000001 / 0", awready, wready, bvalid, arready, rvalid, uart_tx, rdata);
        end
        @(negedge clk);
        reset = 1'b0;
        axi_read(A_STATUS, d, 0);
        checks++; if (d !== 32'h0000_0008) begin failures++; $display("FAIL reset_status: got %h need %h", d, 32'h8); end
        axi_read(A_DIV, d, 0);
        checks++; if (d !== 32'h0000_0364) begin failures++; $display("FAIL reset_div: got %h need %h", d, 32'h364); end
    endtask

    task automatic test_registers();
        logic [31:0] d;
        do_reset();
        axi_write(A_DIV, 32'hABCD_1234, 4'b0001, 0);
        axi_read(A_DIV, d, 0);
        checks++; if (d !== 32'h0000_0334) begin failures++; $display("FAIL div_lane0: got %h need %h", d, 32'h334); end
        axi_write(A_DIV, 32'h0000_5600, 4'b0010, 0);
        axi_read(A_DIV, d, 0);
        checks++; if (d !== 32'h0000_5634) begin failures++; $display("FAIL div_lane1: got %h need %h", d, 32'h5634); end
        axi_write(32'hFFFF_F018, 32'hFFFF_0010, 4'b1111, 0);
        axi_read(32'h0000_1018, d, 3);
        checks++; if (d !== 32'h0000_0010) begin failures++; $display("FAIL div_alias: got %h need %h", d, 32'h10); end
        axi_read(A_TXDATA, d, 0);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL txdata_read: got %h need 0", d); end
        axi_read(32'h0000_0100, d, 0);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL undecoded_read: got %h need 0", d); end
        axi_write(A_STATUS, 32'hFFFF_FFFF, 4'b1111, 0);
        axi_write(32'h0000_001C, 32'h0000_1234, 4'b1111, 0);
        axi_read(A_DIV, d, 0);
        checks++; if (d !== 32'h0000_0010) begin failures++; $display("FAIL div_after_ro_write: got %h need %h", d, 32'h10); end
        axi_write(A_TXDATA, 32'h0000_0041, 4'b1110, 0);
        axi_read(A_STATUS, d, 0);
        checks++; if (d !== 32'h0000_0008) begin failures++; $display("FAIL no_push_strb: got %h need %h", d, 32'h8); end
    endtask

    task automatic test_concurrent();
        logic [31:0] d;
        fork
            axi_write(A_DIV, 32'h0000_0020, 4'b0011, 0);
            begin
                axi_read(A_STATUS, d, 0);
                checks++; if (d !== 32'h0000_0008) begin failures++; $display("FAIL concurrent_status: got %h need %h", d, 32'h8); end
            end
        join
        axi_read(A_DIV, d, 0);
        checks++; if (d !== 32'h0000_0020) begin failures++; $display("FAIL concurrent_div: got %h need %h", d, 32'h20); end
    endtask

    task automatic test_frame();
        logic [31:0] d;
        do_reset();
        axi_write(A_DIV, 32'd16, 4'b0011, 0);
        fork
            axi_write(A_TXDATA, 32'h55, 4'b0001, 0);
            check_frame(8'h55, 16, 1'b1, "frame_55");
        join
        axi_read(A_STATUS, d, 0);
        checks++; if (d !== 32'h0000_0008 || uart_tx !== 1'b1) begin failures++; $display("FAIL frame_done: status=%h tx=%b need 00000008/1", d, uart_tx); end
    endtask

    task automatic test_back_to_back();
        fork
            begin
                axi_write(A_TXDATA, 32'hA3, 4'b0001, 0);
                axi_write(A_TXDATA, 32'h3C, 4'b0001, 0);
            end
            begin
                check_frame(8'hA3, 16, 1'b1, "b2b_first");
                checks++;
                if (uart_tx !== 1'b1) begin failures++; $display("FAIL b2b_idle_gap: uart_tx=%b need 1", uart_tx); end
                @(negedge clk);
                check_frame(8'h3C, 16, 1'b0, "b2b_second");
            end
        join
    endtask

    task automatic test_bready_hold();
        fork
            axi_write(A_TXDATA, 32'hC6, 4'b0001, 5);
            check_frame(8'hC6, 16, 1'b1, "bready_hold_frame");
        join
    endtask

    task automatic test_min_div();
        axi_write(A_DIV, 32'd2, 4'b0011, 0);
        fork
            axi_write(A_TXDATA, 32'hFF, 4'b0001, 0);
            check_frame(8'hFF, 4, 1'b1, "min_div_frame");
        join
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        int          n = 0;
        int          t_start = 0;
        do_reset();
        axi_write(A_DIV, 32'd16, 4'b0011, 0);
        fork
            for (int i = 0; i < 17; i++) axi_write(A_TXDATA, 32'(i + 1), 4'b0001, 0);
            begin
                while (uart_tx !== 1'b0 && n < 200) begin @(negedge clk); n++; end
                t_start = cyc;
                checks++;
                if (uart_tx !== 1'b0) begin failures++; $display("FAIL ovf_first_start: uart_tx=%b need 0", uart_tx); end
            end
        join
        axi_read(A_STATUS, d, 0);
        checks++; if (d !== 32'h0000_0030) begin failures++; $display("FAIL ovf_full: got %h need %h", d, 32'h30); end
        // 18th byte and a STATUS read hit their handshakes in the same cycle.
        fork
            axi_write(A_TXDATA, 32'h12, 4'b0001, 0);
            begin
                axi_read(A_STATUS, d, 0);
                checks++; if (d !== 32'h0000_0030) begin failures++; $display("FAIL ovf_same_cycle: got %h need %h", d, 32'h30); end
            end
        join
        axi_read(A_STATUS, d, 0);
        checks++; if (d !== 32'h0000_0130) begin failures++; $display("FAIL ovf_sticky: got %h need %h", d, 32'h130); end
        axi_read(A_STATUS, d, 0);
        checks++; if (d !== 32'h0000_0030) begin failures++; $display("FAIL ovf_cleared: got %h need %h", d, 32'h30); end
        // 17 frames of 160 cycles plus 16 idle gaps end 2736 cycles after the
        // first start bit; an accepted 18th byte would keep the line busy.
        while (cyc < t_start + 2745) @(negedge clk);
        axi_read(A_STATUS, d, 0);
        checks++; if (d !== 32'h0000_0008) begin failures++; $display("FAIL ovf_drained: got %h need %h", d, 32'h8); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        int          n = 0;
        int          bad = 0;
        do_reset();
        axi_write(A_DIV, 32'd16, 4'b0011, 0);
        fork
            begin
                axi_write(A_TXDATA, 32'hA5, 4'b0001, 0);
                axi_write(A_TXDATA, 32'h0F, 4'b0001, 0);
            end
            begin
                while (uart_tx !== 1'b0 && n < 100) begin @(negedge clk); n++; end
                repeat (70) @(negedge clk);
            end
        join
        checks++;
        if (uart_tx !== 1'b0) begin failures++; $display("FAIL midframe_bit3: uart_tx=%b need 0", uart_tx); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1) begin failures++; $display("FAIL midframe_abort: uart_tx=%b need 1", uart_tx); end
        reset = 1'b0;
        axi_read(A_STATUS, d, 0);
        checks++; if (d !== 32'h0000_0008) begin failures++; $display("FAIL midframe_status: got %h need %h", d, 32'h8); end
        for (int i = 0; i < 400; i++) begin
            if (uart_tx !== 1'b1) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL midframe_residual: uart_tx low on %0d cycles, need 0", bad); end
    endtask

    initial begin
        test_reset();
        test_registers();
        test_concurrent();
        test_frame();
        test_back_to_back();
        test_bready_hold();
        test_min_div();
        test_overflow();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish by time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_axi_tx.md
UART_AXI_TX -- requirements
Module: uart_axi_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, TX FIFO entries (power of two, 4..256).
REQ-002 SHALL have parameter DEFAULT_DIV, default 868, reset value of baud divisor (clk cycles per bit).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have ports mem_axi_awvalid input 1, mem_axi_awready output 1, mem_axi_awaddr input 32, mem_axi_awprot input 3  AXI4-Lite write address.
REQ-007 SHALL have ports mem_axi_wvalid input 1, mem_axi_wready output 1, mem_axi_wdata input 32, mem_axi_wstrb input 4  write data.
REQ-008 SHALL have ports mem_axi_bvalid output 1, mem_axi_bready input 1  write response (no resp field).
REQ-009 SHALL have ports mem_axi_arvalid input 1, mem_axi_arready output 1, mem_axi_araddr input 32, mem_axi_arprot input 3  read address.
REQ-010 SHALL have ports mem_axi_rvalid output 1, mem_axi_rready input 1, mem_axi_rdata output 32  read data.
REQ-011 SHALL have port uart_tx  output  1  serial line, idle high.

Function
REQ-012 SHALL decode only addr[11:0]: 0x018 DIV (rw, bits[15:0]), 0x02C STATUS (ro), 0x030 TXDATA (wo, bits[7:0]); awprot/arprot ignored.
REQ-013 STATUS SHALL be: bit3 FIFO empty, bit4 FIFO full, bit5 serializer busy, bit8 sticky overflow; other bits 0.
REQ-014 Write: awready and wready SHALL pulse high together for exactly one cycle when awvalid && wvalid && !bvalid; never one without the other.
REQ-015 bvalid SHALL rise the cycle after the AW/W handshake and hold until bready is sampled high.
REQ-016 A TXDATA write with wstrb[0]=1 SHALL push wdata[7:0] into the FIFO at the handshake cycle; wstrb[0]=0 pushes nothing.
REQ-017 TXDATA write while FIFO full SHALL drop the byte, set overflow, still complete with bvalid.
REQ-018 DIV write SHALL update per-byte wstrb[1:0]; wdata[31:16] ignored.
REQ-019 Writes to undecoded or read-only addresses SHALL be acknowledged and have no effect.
REQ-020 Read: arready SHALL pulse one cycle when arvalid && !rvalid; rdata/rvalid valid next cycle, both held stable until rready.
REQ-021 DIV reads return {16'h0, div}; TXDATA and undecoded reads return 0.
REQ-022 Reading STATUS SHALL clear overflow in the handshake cycle; an overflow in that same cycle SHALL leave overflow set.
REQ-023 Read and write channels SHALL operate concurrently and independently.
REQ-024 Serializer FSM SHALL have states IDLE, START, DATA, STOP.
REQ-025 IDLE: uart_tx=1; when FIFO non-empty pop one byte, latch byte and divisor, go START next cycle.
REQ-026 START drives 0, DATA drives bits 0..7 LSB first, STOP drives 1; each bit lasts exactly max(div,4) cycles of the latched divisor.
REQ-027 STOP -> IDLE after one bit time; back-to-back bytes SHALL therefore have exactly 1 IDLE cycle between STOP and next START.
REQ-028 DIV changes mid-frame SHALL take effect at the next frame start only.
REQ-029 Simultaneous push and pop SHALL both occur; FIFO count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-030 busy = state != IDLE; FIFO empty/full reflect occupancy including a push in the previous cycle.

Reset
REQ-031 On reset: awready=wready=bvalid=arready=rvalid=0, rdata=0, uart_tx=1, state IDLE, FIFO empty, overflow 0, div=DEFAULT_DIV.
REQ-032 Reset mid-frame SHALL abort the frame, drive uart_tx=1 the next cycle, discard FIFO contents and pending responses.

Verification
REQ-033 After reset read 0x02C -> rdata=0x00000008; read 0x018 -> 0x00000364.
REQ-034 Write div=16, then TXDATA 0x55 -> uart_tx low 16 cycles, then 1,0,1,0,1,0,1,0 each 16 cycles, high 16 cycles; frame 160 cycles.
REQ-035 Write 18 bytes with div=16, no waits, FIFO_DEPTH=16 -> STATUS bit4 set after 17th push (one already popped), 18th dropped, bit8 set; second STATUS read shows bit8=0.
REQ-036 Hold bready low 5 cycles after TXDATA write -> bvalid stays high, no further awready/wready; byte transmitted normally.
REQ-037 Write div=2 then TXDATA 0xFF -> each bit lasts 4 cycles.
REQ-038 Assert reset during DATA bit 3 -> uart_tx=1 next cycle, STATUS afterwards 0x00000008, no residual bytes sent.
